acc_requant: RTL and testbench
==============================

# acc_requant

Output-side requantizer for the MAC array. It drains signed ACC_SIZE-bit accumulator values and converts them back to signed VAR_SIZE-bit operands, the width the MACs consume as `a`/`b`, so that results can be written back as inputs to the next layer. Each value is scaled, rounded, optionally passed through ReLU, offset by a zero point and saturated. The block is a 3-stage valid/ready pipeline sitting between the accumulator readout and the result buffer.

## Interface
- VAR_SIZE, 8, output operand width (signed)
- ACC_SIZE, 32, input accumulator width (signed)
- SCALE_SIZE, 16, multiplier width (signed)
- SHIFT_SIZE, 6, right-shift amount width (unsigned)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_acc is valid
- in_ready  out  1  block accepts in_acc this cycle
- in_acc  in  ACC_SIZE  signed accumulator value
- cfg_scale  in  SCALE_SIZE  signed multiplier
- cfg_shift  in  SHIFT_SIZE  arithmetic right shift applied after the multiply
- cfg_zero  in  VAR_SIZE  signed output zero point
- cfg_relu  in  1  1 = clamp negative rounded values to 0 before the zero point is added
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  VAR_SIZE  signed requantized result
- busy  out  1  at least one pipeline stage holds a valid beat
- sat_flag  out  1  sticky: set when any output saturated
- sat_clr  in  1  synchronous clear of sat_flag

## Operation
- Width rule: P = ACC_SIZE+SCALE_SIZE. Every intermediate value is kept at full width (P+1 bits); nothing is truncated before saturation.
- S1: prod = in_acc * cfg_scale, signed, P bits.
- S2: let sh = min(cfg_shift, P-1).
  - sh = 0: r = prod.
  - Otherwise: r = (prod + 2^(sh-1)) >>> sh. This is round-half-up: 125.5 → 126, -125.5 → -125.
- S3:
  - If cfg_relu and r < 0, then r = 0.
  - s = r + cfg_zero, sign-extended.
  - out = clamp(s, -2^(VAR_SIZE-1), 2^(VAR_SIZE-1)-1).
  - If clamping occurred, sat_flag is set when the beat is loaded into the output register.
- sat_flag precedence: when a set and sat_clr occur in the same cycle, the set wins.
- cfg_* are quasi-static. They may change only while busy = 0; results are undefined otherwise. They are not captured per beat.
- Ordering is strictly in order; no beat is dropped or duplicated.

## Timing
- Reset values: out_valid = 0, out_data = 0, sat_flag = 0, busy = 0, all stage valid bits 0.
- Reset asserted mid-stream discards every in-flight beat immediately (asynchronous). in_ready is 1 after release, provided out_ready = 1 or the pipeline is empty.
- Advance rule: adv = !out_valid || out_ready.
  - When adv = 1, all stages shift by one and S1 loads (in_valid && in_ready).
  - When adv = 0, every stage holds.
- in_ready = adv. This is a combinational path from out_ready. Bubbles are not collapsed.
- Latency: a beat accepted in cycle N appears with out_valid = 1 in cycle N+3 when no stall occurs.
- Throughput: 1 beat/cycle while out_ready = 1.
- Output stability: out_data and out_valid hold stable while out_valid && !out_ready.
- Simultaneous events: transfer on the output and acceptance on the input in the same cycle are both permitted.
- Empty pipeline: out_valid = 0 and busy = 0. The registered out_data keeps its last value.

## Test plan
- Rounding: scale = 1, shift = 3, zero = 0, relu = 0.
  - acc = 1000 → 125.
  - acc = 1004 → 126.
  - acc = -1004 → -125.
  - Each result appears 3 cycles after acceptance.
- Saturation, shift = 0, scale = 1:
  - acc = 100000 → 127, sat_flag = 1.
  - acc = -100000 → -128.
  - Pulsing sat_clr then clears sat_flag to 0.
- ReLU and zero point, scale = 1, shift = 0, zero = 10:
  - relu = 1, acc = -50 → 10.
  - relu = 0, acc = -50 → -40.
  - relu = 0, acc = 120 → 127 (saturated).
- Scale: scale = -3, shift = 1, acc = 7 → -21 >>> 1 with rounding → -10.
- Backpressure: stream acc = 1..8 back-to-back (scale = 1, shift = 0), hold out_ready = 0 for 5 cycles from cycle 4.
  - in_ready = 0 throughout the stall.
  - out_data is held during the stall.
  - Outputs appear exactly 1..8 in order.
- Reset mid-stream: assert rst with 3 beats in flight.
  - out_valid, busy and sat_flag go to 0 without waiting for a clock edge.
  - After release, the next beat acc = 5 emerges as 5 with 3-cycle latency.

Source files
------------

// File: rtl/acc_requant.sv
// Accumulator-to-operand requantizer: multiply, round-half-up shift, optional ReLU,
// zero-point offset and saturation, as a 3-stage valid/ready pipeline.
module acc_requant #(
  parameter int VAR_SIZE   = 8,
  parameter int ACC_SIZE   = 32,
  parameter int SCALE_SIZE = 16,
  parameter int SHIFT_SIZE = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_SIZE-1:0]   in_acc,
  input  logic signed [SCALE_SIZE-1:0] cfg_scale,
  input  logic        [SHIFT_SIZE-1:0] cfg_shift,
  input  logic signed [VAR_SIZE-1:0]   cfg_zero,
  input  logic                         cfg_relu,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [VAR_SIZE-1:0]   out_data,
  output logic                         busy,
  output logic                         sat_flag,
  input  logic                         sat_clr
);
  localparam int P      = ACC_SIZE + SCALE_SIZE;
  localparam int W      = P + 1;
  localparam int STAGES = 3;

  localparam logic signed [W-1:0] OMAX = {{(W-VAR_SIZE+1){1'b0}}, {(VAR_SIZE-1){1'b1}}};
  localparam logic signed [W-1:0] OMIN = {{(W-VAR_SIZE+1){1'b1}}, {(VAR_SIZE-1){1'b0}}};

  logic [STAGES:1]           vld_pipe_q;
  logic                      adv;
  logic signed [P-1:0]       prod_d, prod_q;
  logic signed [W-1:0]       prod_x, rnd, r_d, r_q;
  logic signed [W-1:0]       rr, s;
  logic signed [VAR_SIZE-1:0] res_d, out_data_q;
  logic                      sat_d, sat_flag_q;
  int                        sh_i;

  // Whole pipeline moves as one; bubbles are not collapsed.
  assign adv       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign out_data  = out_data_q;
  assign busy      = |vld_pipe_q;
  assign sat_flag  = sat_flag_q;

  assign prod_d = P'(in_acc) * P'(cfg_scale);

  always_comb begin
    sh_i   = (int'(cfg_shift) > P - 1) ? P - 1 : int'(cfg_shift);
    prod_x = W'(prod_q);
    rnd    = '0;
    if (sh_i != 0) rnd = W'(1) << (sh_i - 1);
    r_d    = (prod_x + rnd) >>> sh_i;
  end

  always_comb begin
    rr    = (cfg_relu && r_q < 0) ? '0 : r_q;
    s     = rr + W'(cfg_zero);
    sat_d = 1'b0;
    res_d = s[VAR_SIZE-1:0];
    if (s > OMAX) begin
      res_d = OMAX[VAR_SIZE-1:0];
      sat_d = 1'b1;
    end else if (s < OMIN) begin
      res_d = OMIN[VAR_SIZE-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      prod_q     <= '0;
      r_q        <= '0;
      out_data_q <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      if (adv) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
        if (in_valid)      prod_q     <= prod_d;
        if (vld_pipe_q[1]) r_q        <= r_d;
        if (vld_pipe_q[2]) out_data_q <= res_d;
      end
      // A saturating load beats a same-cycle clear.
      if (adv && vld_pipe_q[2] && sat_d) sat_flag_q <= 1'b1;
      else if (sat_clr)                  sat_flag_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acc_requant.sv
// Randomized and directed bench for acc_requant against a plain-arithmetic reference model.
module tb_acc_requant;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_acc = '0;
  logic signed [15:0] cfg_scale = 16'sd1;
  logic        [5:0]  cfg_shift = '0;
  logic signed [7:0]  cfg_zero = '0;
  logic               cfg_relu = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [7:0]  out_data;
  logic               busy;
  logic               sat_flag;
  logic               sat_clr = 1'b0;

  acc_requant dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zero(cfg_zero), .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [7:0] d; bit sat; } exp_t;
  exp_t               q[$];
  logic signed [7:0]  got[$];
  bit                 sticky = 1'b0;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input longint acc, input longint scale, input int shift,
                                 input longint zero, input bit relu);
    exp_t   e;
    longint p, r, s;
    int     sh;
    p  = acc * scale;
    sh = (shift > 47) ? 47 : shift;
    r  = (sh == 0) ? p : ((p + (longint'(1) << (sh - 1))) >>> sh);
    if (relu && r < 0) r = 0;
    s     = r + zero;
    e.sat = (s > 127) || (s < -128);
    e.d   = (s > 127) ? 8'sd127 : (s < -128) ? -8'sd128 : 8'(s);
    return e;
  endfunction

  // Every cycle: occupancy, handshake, data and sticky flag against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      sticky = 1'b0;
    end else begin
      chk("busy", busy, q.size() != 0);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious out_valid", 1, 0);
        else begin
          chk("out_data", out_data, q[0].d);
          chk("sat_flag", sat_flag, sticky | q[0].sat);
          if (out_ready) begin
            sticky = sticky | q[0].sat;
            got.push_back(out_data);
            void'(q.pop_front());
          end
        end
      end else chk("sat_flag idle", sat_flag, sticky);
      if (sat_clr) sticky = 1'b0;
      if (in_valid && in_ready)
        q.push_back(model(longint'(in_acc), longint'(cfg_scale), int'(cfg_shift),
                          longint'(cfg_zero), cfg_relu));
    end
  end

  task automatic cfg(input logic signed [15:0] sc, input logic [5:0] sh,
                     input logic signed [7:0] z, input logic rl);
    cfg_scale = sc; cfg_shift = sh; cfg_zero = z; cfg_relu = rl;
  endtask

  task automatic one(input logic signed [31:0] acc, input logic signed [7:0] exp, input string nm);
    int lat;
    in_acc = acc; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1 lat++;
    end
    chk({nm, " latency"}, lat, 3);
    chk(nm, out_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((busy || out_valid) && t < 50) begin
      @(posedge clk); #1 t++;
    end
    chk({nm, " drain timeout"}, t < 50, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic signed [7:0] held;
    #2 rst = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset sat_flag", sat_flag, 0);
    chk("reset busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready after reset", in_ready, 1);

    cfg(16'sd1, 6'd3, 8'sd0, 1'b0);
    one(1000, 8'sd125, "round 1000");
    one(1004, 8'sd126, "round 1004");
    one(-1004, -8'sd125, "round -1004");

    cfg(16'sd1, 6'd0, 8'sd0, 1'b0);
    one(100000, 8'sd127, "sat pos");
    chk("sat_flag set", sat_flag, 1);
    one(-100000, -8'sd128, "sat neg");
    sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;
    chk("sat_flag cleared", sat_flag, 0);

    cfg(16'sd1, 6'd0, 8'sd10, 1'b1);
    one(-50, 8'sd10, "relu zp");
    cfg(16'sd1, 6'd0, 8'sd10, 1'b0);
    one(-50, -8'sd40, "zp no relu");
    one(120, 8'sd127, "zp sat");
    chk("zp sat flag", sat_flag, 1);
    sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;

    cfg(-16'sd3, 6'd1, 8'sd0, 1'b0);
    one(7, -8'sd10, "neg scale");

    // Backpressure: 1..8 back-to-back with a 5-cycle output stall.
    cfg(16'sd1, 6'd0, 8'sd0, 1'b0);
    got.delete();
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          in_acc = i; in_valid = 1'b1;
          do begin
            @(negedge clk) ok = in_ready;
            @(posedge clk); #1;
          end while (!ok);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) held = out_data;
          chk("stall in_ready", in_ready, 0);
          chk("stall out_valid", out_valid, 1);
          chk("stall out_data held", out_data, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain("backpressure");
    chk("bp count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp order", got[i], i + 1);

    // Reset with beats in flight.
    one(100000, 8'sd127, "pre-reset sat");
    for (int i = 1; i <= 3; i++) begin
      in_acc = i; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst sat_flag", sat_flag, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    one(5, 8'sd5, "post-reset");

    // Randomized traffic over several configurations.
    for (int c = 0; c < 8; c++) begin
      cfg(16'($urandom), (c == 7) ? 6'd63 : 6'($urandom_range(0, 20)),
          8'($urandom), 1'($urandom));
      if (c == 0) cfg(16'sd1, 6'd0, 8'sd0, 1'b0);
      for (int n = 0; n < 200; n++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
          0:       in_acc = 32'($signed($urandom_range(0, 600)) - 300);
          1:       in_acc = 32'($urandom);
          default: in_acc = 32'($signed($urandom_range(0, 200000)) - 100000);
        endcase
        @(posedge clk); #1;
      end
      drain("random");
      if (sat_flag || sticky) begin
        sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;
      end
    end
    chk("model queue empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
